// File: rtl/bus_owner_switcher_pkg.sv
// switcher_pkg: shared types and helpers for bus_owner_switcher.
//   state_t      hand-over FSM states
//   STROBE_IDLE  inactive level of every active-low pin strobe
//   flat_slice   extracts client k's field from a flattened per-client vector
package switcher_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic STROBE_IDLE = 1'b1;

    // Widest field and widest flattened vector the slice helper handles.
    // N_CLIENTS*ADDR_W and N_CLIENTS*DATA_W must fit in FLAT_MAX_W.
    localparam int SLICE_MAX_W = 64;
    localparam int FLAT_MAX_W  = 4096;

    // Field idx of width w from a flat vector (field k lives at [k*w +: w]).
    function automatic logic [SLICE_MAX_W-1:0] flat_slice(
        input logic [FLAT_MAX_W-1:0] flat,
        input int                    idx,
        input int                    w
    );
        return SLICE_MAX_W'(flat >> (idx * w)) & ~({SLICE_MAX_W{1'b1}} << w);
    endfunction

endpackage

// File: rtl/bus_owner_switcher_if.sv
// bus_owner_switcher_if: client-side and pin-side bus signals of the switcher
// (everything except clk, rst and the tri-state SRAM data pins).
//   master modport: the switcher itself (reads client requests, drives pins/grants)
//   slave  modport: the clients/board side
interface bus_owner_switcher_if #(
    parameter int N_CLIENTS = 2,
    parameter int ADDR_W    = 18,
    parameter int DATA_W    = 16,
    parameter int SEL_W     = $clog2(N_CLIENTS)
);
    logic [SEL_W-1:0]            sel;
    logic [N_CLIENTS*ADDR_W-1:0] cli_addr;
    logic [N_CLIENTS*DATA_W-1:0] cli_dout;
    logic [N_CLIENTS-1:0]        cli_oe_n;
    logic [N_CLIENTS-1:0]        cli_we_n;
    logic [N_CLIENTS-1:0]        cli_en_n;
    logic [N_CLIENTS-1:0]        cli_rdn;
    logic [N_CLIENTS-1:0]        cli_wrn;
    logic [N_CLIENTS-1:0]        cli_busy;
    logic [N_CLIENTS-1:0]        cli_grant;
    logic [DATA_W-1:0]           cli_din;
    logic [ADDR_W-1:0]           ram_addr;
    logic                        ram_oe_n;
    logic                        ram_we_n;
    logic                        ram_en_n;
    logic                        rdn;
    logic                        wrn;
    logic [SEL_W-1:0]            owner;
    logic                        switching;
    logic                        timeout_err;

    modport master (
        input  sel, cli_addr, cli_dout, cli_oe_n, cli_we_n, cli_en_n,
               cli_rdn, cli_wrn, cli_busy,
        output cli_grant, cli_din, ram_addr, ram_oe_n, ram_we_n, ram_en_n,
               rdn, wrn, owner, switching, timeout_err
    );

    modport slave (
        output sel, cli_addr, cli_dout, cli_oe_n, cli_we_n, cli_en_n,
               cli_rdn, cli_wrn, cli_busy,
        input  cli_grant, cli_din, ram_addr, ram_oe_n, ram_we_n, ram_en_n,
               rdn, wrn, owner, switching, timeout_err
    );
endinterface

// File: rtl/bus_owner_switcher_sync_2ff.sv
// sync_2ff: two-flop synchroniser for a slow asynchronous board input.
//   clk, rst (async, active-low) | d: async input | q: synchronised output
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/bus_owner_switcher.sv
// bus_owner_switcher: hands one SRAM port plus the UART strobes to one of
// N_CLIENTS machines, chosen by the async board input sel. A change of owner
// lets the old owner drain (bounded by DRAIN_TIMEOUT), forces every pin strobe
// idle for GAP_CYCLES cycles, then grants the new owner.
//   clk, rst       clock, async active-low reset
//   bus (master)   sel, per-client requests/busy, grants, pin outputs, status
//   ram_data       SRAM data pins (tri-state; kept as a plain inout port)
module bus_owner_switcher
    import switcher_pkg::*;
#(
    parameter int N_CLIENTS     = 2,
    parameter int ADDR_W        = 18,
    parameter int DATA_W        = 16,
    parameter int SEL_W         = $clog2(N_CLIENTS),
    parameter int GAP_CYCLES    = 2,
    parameter int DRAIN_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    bus_owner_switcher_if.master bus,
    inout  wire  [DATA_W-1:0]   ram_data
);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int DRN_W = $clog2(DRAIN_TIMEOUT + 1);

    logic [SEL_W-1:0] sel_s;
    state_t           state_q, state_d;
    logic [SEL_W-1:0] owner_q, owner_d, target_q, target_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [DRN_W-1:0] drn_q, drn_d;
    logic             tmo_q, tmo_d;
    logic             sel_req;

    logic              oe_q, we_q, en_q, rdn_q, wrn_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] dout_q;
    logic              drive;

    sync_2ff #(.WIDTH(SEL_W)) u_sel_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.sel),
        .q   (sel_s)
    );

    // Out-of-range selects (possible when N_CLIENTS is not a power of 2) are ignored.
    assign sel_req = (32'(sel_s) < 32'(N_CLIENTS)) && (sel_s != owner_q);

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        target_d = target_q;
        gap_d    = gap_q;
        drn_d    = drn_q;
        tmo_d    = 1'b0;
        unique case (state_q)
            RUN: begin
                if (sel_req) begin
                    target_d = sel_s;
                    drn_d    = DRN_W'(1);
                    state_d  = DRAIN;
                end
            end
            DRAIN: begin
                // drn_q counts DRAIN cycles including the current one.
                if (!bus.cli_busy[owner_q] || drn_q == DRN_W'(DRAIN_TIMEOUT)) begin
                    tmo_d   = bus.cli_busy[owner_q];
                    owner_d = target_q;
                    gap_d   = GAP_W'(GAP_CYCLES - 1);
                    state_d = GAP;
                end else begin
                    drn_d = drn_q + DRN_W'(1);
                end
            end
            GAP: begin
                if (gap_q == '0) state_d = RUN;
                else             gap_d   = gap_q - GAP_W'(1);
            end
            default: state_d = GAP;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= GAP;
            gap_q    <= GAP_W'(GAP_CYCLES - 1);
            drn_q    <= '0;
            owner_q  <= '0;
            target_q <= '0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            drn_q    <= drn_d;
            owner_q  <= owner_d;
            target_q <= target_d;
            tmo_q    <= tmo_d;
        end
    end

    // Pin registers are loaded for the state being entered, so the pins are
    // idle for exactly the GAP cycles. Address/data simply hold during GAP;
    // only the strobes matter to the devices.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            oe_q   <= STROBE_IDLE;
            we_q   <= STROBE_IDLE;
            en_q   <= STROBE_IDLE;
            rdn_q  <= STROBE_IDLE;
            wrn_q  <= STROBE_IDLE;
            addr_q <= '0;
            dout_q <= '0;
        end else if (state_d == GAP) begin
            oe_q  <= STROBE_IDLE;
            we_q  <= STROBE_IDLE;
            en_q  <= STROBE_IDLE;
            rdn_q <= STROBE_IDLE;
            wrn_q <= STROBE_IDLE;
        end else begin
            oe_q   <= bus.cli_oe_n[owner_q];
            we_q   <= bus.cli_we_n[owner_q];
            en_q   <= bus.cli_en_n[owner_q];
            rdn_q  <= bus.cli_rdn[owner_q];
            wrn_q  <= bus.cli_wrn[owner_q];
            addr_q <= ADDR_W'(flat_slice(FLAT_MAX_W'(bus.cli_addr), int'(owner_q), ADDR_W));
            dout_q <= DATA_W'(flat_slice(FLAT_MAX_W'(bus.cli_dout), int'(owner_q), DATA_W));
        end
    end

    assign drive    = (we_q == 1'b0) && (en_q == 1'b0) && (state_q != GAP);
    assign ram_data = drive ? dout_q : {DATA_W{1'bz}};

    assign bus.cli_din     = ram_data;
    assign bus.cli_grant   = (state_q == RUN) ? (N_CLIENTS'(1) << owner_q) : '0;
    assign bus.ram_addr    = addr_q;
    assign bus.ram_oe_n    = oe_q;
    assign bus.ram_we_n    = we_q;
    assign bus.ram_en_n    = en_q;
    assign bus.rdn         = rdn_q;
    assign bus.wrn         = wrn_q;
    assign bus.owner       = owner_q;
    assign bus.switching   = (state_q != RUN);
    assign bus.timeout_err = tmo_q;
endmodule

// File: tb/tb_bus_owner_switcher.sv
// Scoreboard bench: stimulus pushes expected (value, cycle) events per kind;
// a monitor pops and compares whenever the DUT shows that kind of event.
module tb_bus_owner_switcher;
    localparam int N  = 3;
    localparam int AW = 18;
    localparam int DW = 16;
    localparam int SW = 2;

    typedef struct {
        logic [63:0] val;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    wire [DW-1:0] ram_data;
    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    exp_t q_grant[$];
    exp_t q_rdn[$];
    exp_t q_tmo[$];
    exp_t q_wr[$];

    bus_owner_switcher_if #(.N_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .SEL_W(SW)) bus ();

    bus_owner_switcher #(
        .N_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW), .SEL_W(SW),
        .GAP_CYCLES(2), .DRAIN_TIMEOUT(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .ram_data (ram_data)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input logic [63:0] v, input int c);
        exp_t e;
        e.val = v;
        e.cyc = c;
        return e;
    endfunction

    function automatic logic [63:0] gval(input logic [SW-1:0] own, input logic [N-1:0] g);
        return 64'({own, g});
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        logic [N-1:0] prev_grant;
        logic         prev_rdn;
        exp_t         e;
        prev_grant = '0;
        prev_rdn   = 1'b1;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (bus.cli_grant != prev_grant) begin
                checks++;
                if (q_grant.size() == 0) begin
                    errors++;
                    $display("FAIL grant: unexpected change to %b at cycle %0d", bus.cli_grant, cyc);
                end else begin
                    e = q_grant.pop_front();
                    if (gval(bus.owner, bus.cli_grant) != e.val || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL grant: got %h at cycle %0d expected %h at cycle %0d",
                                 gval(bus.owner, bus.cli_grant), cyc, e.val, e.cyc);
                    end
                end
                prev_grant = bus.cli_grant;
            end
            if (bus.rdn != prev_rdn) begin
                checks++;
                if (q_rdn.size() == 0) begin
                    errors++;
                    $display("FAIL rdn: unexpected change to %b at cycle %0d", bus.rdn, cyc);
                end else begin
                    e = q_rdn.pop_front();
                    if (64'(bus.rdn) != e.val || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL rdn: got %b at cycle %0d expected %0d at cycle %0d",
                                 bus.rdn, cyc, e.val, e.cyc);
                    end
                end
                prev_rdn = bus.rdn;
            end
            if (bus.timeout_err) begin
                checks++;
                if (q_tmo.size() == 0) begin
                    errors++;
                    $display("FAIL timeout_err: unexpected pulse at cycle %0d", cyc);
                end else begin
                    e = q_tmo.pop_front();
                    if (cyc != e.cyc) begin
                        errors++;
                        $display("FAIL timeout_err: pulse at cycle %0d expected at cycle %0d", cyc, e.cyc);
                    end
                end
            end
            if (!bus.ram_we_n && !bus.ram_en_n) begin
                checks++;
                if (q_wr.size() == 0) begin
                    errors++;
                    $display("FAIL write: unexpected pin write at cycle %0d", cyc);
                end else begin
                    e = q_wr.pop_front();
                    if (64'({bus.ram_addr, ram_data, bus.cli_din}) != e.val || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL write: got %h at cycle %0d expected %h at cycle %0d",
                                 64'({bus.ram_addr, ram_data, bus.cli_din}), cyc, e.val, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        bus.sel      = 2'd1;
        bus.cli_addr = '0;
        bus.cli_addr[2*AW +: AW] = 18'h2ABCD;
        bus.cli_dout = '0;
        bus.cli_oe_n = '1;
        bus.cli_we_n = '1;
        bus.cli_en_n = '1;
        bus.cli_rdn  = '0;    // every client holds its UART read strobe active
        bus.cli_wrn  = '1;
        bus.cli_busy = '0;

        // Reset held with sel=1: pins idle, no grant.
        repeat (3) @(negedge clk);
        chk("rst_grant", 64'(bus.cli_grant), 64'd0);
        chk("rst_strobes", 64'({bus.ram_oe_n, bus.ram_we_n, bus.ram_en_n, bus.rdn, bus.wrn}), 64'h1F);
        chk("rst_owner", 64'(bus.owner), 64'd0);
        chk("rst_addr", 64'(bus.ram_addr), 64'd0);
        chk("rst_switching", 64'(bus.switching), 64'd1);
        chk("rst_timeout", 64'(bus.timeout_err), 64'd0);

        // Release: client 0 granted after 2 edges, then sel=1 is honoured.
        n = cyc;
        rst = 1'b1;
        q_grant.push_back(mk(gval(2'd0, 3'b001), n + 2));
        q_grant.push_back(mk(gval(2'd0, 3'b000), n + 3));
        q_grant.push_back(mk(gval(2'd1, 3'b010), n + 6));
        q_rdn.push_back(mk(64'd0, n + 2));
        q_rdn.push_back(mk(64'd1, n + 4));
        q_rdn.push_back(mk(64'd0, n + 6));
        wait_until(n + 9);
        chk("t1_owner", 64'(bus.owner), 64'd1);
        chk("t1_switching", 64'(bus.switching), 64'd0);

        // Clean switch 1 -> 2.
        n = cyc;
        bus.sel = 2'd2;
        q_grant.push_back(mk(gval(2'd1, 3'b000), n + 3));
        q_grant.push_back(mk(gval(2'd2, 3'b100), n + 6));
        q_rdn.push_back(mk(64'd1, n + 4));
        q_rdn.push_back(mk(64'd0, n + 6));
        wait_until(n + 9);

        // Out-of-range select: nothing moves.
        bus.sel = 2'd3;
        wait_until(cyc + 10);
        chk("oor_owner", 64'(bus.owner), 64'd2);
        chk("oor_switching", 64'(bus.switching), 64'd0);
        chk("oor_grant", 64'(bus.cli_grant), 64'b100);
        chk("oor_addr", 64'(bus.ram_addr), 64'h2ABCD);

        // Switch 2 -> 0.
        n = cyc;
        bus.sel = 2'd0;
        q_grant.push_back(mk(gval(2'd2, 3'b000), n + 3));
        q_grant.push_back(mk(gval(2'd0, 3'b001), n + 6));
        q_rdn.push_back(mk(64'd1, n + 4));
        q_rdn.push_back(mk(64'd0, n + 6));
        wait_until(n + 9);

        // Drain wait: client 0 busy for 5 DRAIN cycles and writes A5A5 @ 0x10 while draining.
        n = cyc;
        bus.sel = 2'd1;
        bus.cli_busy[0] = 1'b1;
        q_grant.push_back(mk(gval(2'd0, 3'b000), n + 3));
        q_grant.push_back(mk(gval(2'd1, 3'b010), n + 11));
        q_rdn.push_back(mk(64'd1, n + 9));
        q_rdn.push_back(mk(64'd0, n + 11));
        q_wr.push_back(mk(64'({18'h00010, 16'hA5A5, 16'hA5A5}), n + 6));
        wait_until(n + 5);
        bus.cli_we_n[0] = 1'b0;
        bus.cli_en_n[0] = 1'b0;
        bus.cli_addr[0 +: AW] = 18'h00010;
        bus.cli_dout[0 +: DW] = 16'hA5A5;
        wait_until(n + 6);
        bus.cli_we_n[0] = 1'b1;
        bus.cli_en_n[0] = 1'b1;
        wait_until(n + 8);
        bus.cli_busy[0] = 1'b0;
        wait_until(n + 14);

        // Timeout: client 1 stuck busy, 8 DRAIN cycles then forced hand-over to 2.
        n = cyc;
        bus.sel = 2'd2;
        bus.cli_busy[1] = 1'b1;
        q_grant.push_back(mk(gval(2'd1, 3'b000), n + 3));
        q_grant.push_back(mk(gval(2'd2, 3'b100), n + 13));
        q_rdn.push_back(mk(64'd1, n + 11));
        q_rdn.push_back(mk(64'd0, n + 13));
        q_tmo.push_back(mk(64'd1, n + 11));
        wait_until(n + 12);
        bus.cli_busy[1] = 1'b0;
        wait_until(n + 16);

        // Reset mid-GAP during hand-over 2 -> 0.
        n = cyc;
        bus.sel = 2'd0;
        q_grant.push_back(mk(gval(2'd2, 3'b000), n + 3));
        q_rdn.push_back(mk(64'd1, n + 4));
        wait_until(n + 4);
        rst = 1'b0;
        #1;
        chk("gaprst_owner", 64'(bus.owner), 64'd0);
        chk("gaprst_addr", 64'(bus.ram_addr), 64'd0);
        chk("gaprst_strobes", 64'({bus.ram_oe_n, bus.ram_we_n, bus.ram_en_n, bus.rdn, bus.wrn}), 64'h1F);
        chk("gaprst_switching", 64'(bus.switching), 64'd1);
        chk("gaprst_grant", 64'(bus.cli_grant), 64'd0);
        wait_until(n + 6);
        n = cyc;
        rst = 1'b1;
        q_grant.push_back(mk(gval(2'd0, 3'b001), n + 2));
        q_rdn.push_back(mk(64'd0, n + 2));
        wait_until(n + 6);

        chk("left_grant", 64'(q_grant.size()), 64'd0);
        chk("left_rdn", 64'(q_rdn.size()), 64'd0);
        chk("left_tmo", 64'(q_tmo.size()), 64'd0);
        chk("left_wr", 64'(q_wr.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
